// File: rtl/uart_program_loader.sv
// Boot loader: assembles a framed UART byte stream into 32-bit little-endian words, writes them
// to program memory and holds the CPU in reset until the image checksum verifies.
module uart_program_loader #(
    parameter int          MEMORY_DEPTH   = 32,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_lo_q, len_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] words_q, words_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] tmo_q, tmo_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic        accept;
    logic        in_frame;
    logic [31:0] n_full;
    logic [31:0] word_next;

    // The write cycle blocks the input so addr/wdata cannot move while being written.
    assign rx_ready     = (state_q inside {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK}) && !we_q;
    assign accept       = rx_valid && rx_ready;
    assign in_frame     = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
    assign n_full       = {16'd0, rx_data, len_lo_q};
    assign word_next    = {rx_data, word_q[31:8]};

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign words_loaded = words_q;
    assign load_done    = (state_q == S_DONE);
    assign load_error   = (state_q == S_ERROR);
    assign cpu_hold     = (state_q != S_DONE);

    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        n_d        = n_q;
        words_d    = words_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        sum_d      = sum_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SYNC_BYTE) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    n_d        = n_full[15:0];
                    words_d    = 16'd0;
                    byte_cnt_d = 2'd0;
                    sum_d      = 8'd0;
                    if (n_full == 32'd0 || n_full > 32'(MEMORY_DEPTH)) state_d = S_ERROR;
                    else                                                state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    word_d     = word_next;
                    sum_d      = sum_q + rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = BASE_ADDR + {14'd0, words_q, 2'b00};
                        wdata_d = word_next;
                        words_d = words_q + 16'd1;
                        if (words_q + 16'd1 == n_q) state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (accept) state_d = (sum_q + rx_data == 8'h00) ? S_DONE : S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_IDLE;
                    words_d = 16'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted byte beats the timeout in the same cycle.
        if (!in_frame || accept) begin
            tmo_d = 32'd0;
        end else if (tmo_q >= 32'(TIMEOUT_CYCLES - 1)) begin
            tmo_d   = 32'd0;
            state_d = S_ERROR;
        end else begin
            tmo_d = tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_lo_q   <= 8'd0;
            n_q        <= 16'd0;
            words_q    <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_q     <= 32'd0;
            sum_q      <= 8'd0;
            tmo_q      <= 32'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            n_q        <= n_d;
            words_q    <= words_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            sum_q      <= sum_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: good/bad checksum, bad length, garbage prefix,
// inter-byte timeout and asynchronous reset mid-frame.
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic [15:0] words_loaded;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int          wr_cnt  = 0;
    int          we_rdy_viol = 0;

    uart_program_loader #(
        .MEMORY_DEPTH  (32),
        .BASE_ADDR     (32'h0),
        .SYNC_BYTE     (8'hA5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .start       (start),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Log every memory write; the input must be stalled while it happens.
    always @(negedge clk) begin
        if (imem_we) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] = imem_addr;
                wr_data[wr_cnt] = imem_wdata;
            end
            wr_cnt = wr_cnt + 1;
            if (rx_ready) we_rdy_viol = we_rdy_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge on which the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (rx_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!ok) chk("rx_accept", 32'd0, 32'd1);
    endtask

    task automatic send_stream(input logic [7:0] s [], input int n);
        for (int i = 0; i < n; i++) send_byte(s[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    logic [7:0] good [] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20,
                            8'h34, 8'h12, 8'h00, 8'h00, 8'h87};
    logic [7:0] bad  [] = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20,
                            8'h34, 8'h12, 8'h00, 8'h00, 8'h88};
    logic [7:0] badn [] = '{8'hA5, 8'h21, 8'h00};
    logic [7:0] junk [] = '{8'h00, 8'hFF, 8'h5A};

    task automatic check_good(input string t, input int base);
        chk({t, "_wr_cnt"}, 32'(wr_cnt - base), 32'd2);
        chk({t, "_addr0"},  wr_addr[base],       32'h0);
        chk({t, "_data0"},  wr_data[base],       32'h2000_0013);
        chk({t, "_addr1"},  wr_addr[base + 1],   32'h4);
        chk({t, "_data1"},  wr_data[base + 1],   32'h0000_1234);
        chk({t, "_done"},   32'(load_done),      32'd1);
        chk({t, "_error"},  32'(load_error),     32'd0);
        chk({t, "_hold"},   32'(cpu_hold),       32'd0);
        chk({t, "_words"},  32'(words_loaded),   32'd2);
        chk({t, "_ready"},  32'(rx_ready),       32'd0);
    endtask

    initial begin
        int base;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; start = 1'b0;
        tick(2);
        chk("rst_hold",  32'(cpu_hold),     32'd1);
        chk("rst_done",  32'(load_done),    32'd0);
        chk("rst_error", 32'(load_error),   32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_we",    32'(imem_we),      32'd0);
        chk("rst_addr",  imem_addr,         32'd0);
        chk("rst_wdata", imem_wdata,        32'd0);
        reset = 1'b0;
        tick(1);
        chk("idle_ready", 32'(rx_ready), 32'd1);

        // 1: good image
        base = wr_cnt;
        send_stream(good, 12);
        tick(2);
        check_good("t1", base);
        pulse_start();
        chk("t1_start_hold",  32'(cpu_hold),     32'd1);
        chk("t1_start_done",  32'(load_done),    32'd0);
        chk("t1_start_words", 32'(words_loaded), 32'd0);

        // 2: bad checksum
        base = wr_cnt;
        send_stream(bad, 12);
        tick(2);
        chk("t2_wr_cnt", 32'(wr_cnt - base), 32'd2);
        chk("t2_error",  32'(load_error),    32'd1);
        chk("t2_done",   32'(load_done),     32'd0);
        chk("t2_hold",   32'(cpu_hold),      32'd1);
        chk("t2_words",  32'(words_loaded),  32'd2);
        pulse_start();
        chk("t2_start_error", 32'(load_error), 32'd0);

        // 3: length 33 > MEMORY_DEPTH
        base = wr_cnt;
        send_stream(badn, 3);
        chk("t3_error", 32'(load_error), 32'd1);
        chk("t3_ready", 32'(rx_ready),   32'd0);
        tick(3);
        chk("t3_wr_cnt", 32'(wr_cnt - base), 32'd0);
        pulse_start();

        // 4: garbage before SYNC
        base = wr_cnt;
        send_stream(junk, 3);
        send_stream(good, 12);
        tick(2);
        check_good("t4", base);
        pulse_start();

        // 5: stall after 5 data bytes
        base = wr_cnt;
        send_stream(good, 8);
        tick(15);
        chk("t5_err_at15", 32'(load_error), 32'd0);
        tick(1);
        chk("t5_err_at16", 32'(load_error), 32'd1);
        chk("t5_hold",     32'(cpu_hold),   32'd1);
        chk("t5_wr_cnt",   32'(wr_cnt - base), 32'd1);
        chk("t5_data0",    wr_data[base],   32'h2000_0013);
        pulse_start();

        // 6: async reset mid-DATA, then a clean load and a restart
        send_stream(good, 8);
        tick(1);
        chk("t6_pre_words", 32'(words_loaded), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_hold",  32'(cpu_hold),     32'd1);
        chk("t6_rst_words", 32'(words_loaded), 32'd0);
        chk("t6_rst_we",    32'(imem_we),      32'd0);
        chk("t6_rst_addr",  imem_addr,         32'd0);
        chk("t6_rst_wdata", imem_wdata,        32'd0);
        tick(2);
        reset = 1'b0;
        tick(1);
        base = wr_cnt;
        send_stream(good, 12);
        tick(2);
        check_good("t6", base);
        pulse_start();
        chk("t6_start_hold",  32'(cpu_hold),  32'd1);
        chk("t6_start_done",  32'(load_done), 32'd0);
        chk("t6_start_ready", 32'(rx_ready),  32'd1);

        chk("we_ready_overlap", 32'(we_rdy_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
